// File: rtl/rib_pkg.sv
// Shared constants for the RIB interconnect arbiter.
// Master/slave IDs, arbiter state encoding, default slow-slave mask.
package rib_pkg;

  localparam logic [1:0] RIB_M_CORE  = 2'd0;
  localparam logic [1:0] RIB_M_FETCH = 2'd1;
  localparam logic [1:0] RIB_M_JTAG  = 2'd2;
  localparam logic [1:0] RIB_M_UART  = 2'd3;

  localparam logic [2:0] RIB_S0 = 3'd0;
  localparam logic [2:0] RIB_S1 = 3'd1;
  localparam logic [2:0] RIB_S2 = 3'd2;
  localparam logic [2:0] RIB_S3 = 3'd3;
  localparam logic [2:0] RIB_S4 = 3'd4;
  localparam logic [2:0] RIB_S5 = 3'd5;
  localparam logic [2:0] RIB_S6 = 3'd6;
  localparam logic [2:0] RIB_S7 = 3'd7;

  localparam logic [7:0] RIB_SLOW_MASK_DFLT = 8'h80;

  typedef enum logic {
    ARB  = 1'b0,
    BUSY = 1'b1
  } rib_state_e;

endpackage

// File: rtl/rib_rr_pick2.sv
// Two-requester round-robin picker.
// Ports: req_i[1:0] requests, ptr_i preferred side, win_o winner, vld_o any req.
module rib_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       win_o,
  output logic       vld_o
);

  assign vld_o = |req_i;
  // side 1 wins if it is alone, or if both ask and it is preferred
  assign win_o = req_i[1] & (ptr_i | ~req_i[0]);

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter and slow-slave access sequencer (4 masters, 8 slaves).
// Ports: clk/rst (sync, active-high); m_req_i, m_addr_i masters in;
//   grant_o, grant_vld_o, slave_sel_o, unmapped_o to the RIB mux;
//   s_req_o/s_ack_i slow-slave handshake; m_ack_o per-master completion;
//   hold_flag_o core stall; timeout_o abandoned slow access.
// Optional: define RIB_ARB_TIMEOUT_EN to build the BUSY timeout counter.
module rib_arbiter
  import rib_pkg::*;
#(
  parameter int unsigned NUM_SLAVES      = 8,
  parameter logic [7:0]  SLOW_SLAVE_MASK = RIB_SLOW_MASK_DFLT,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   m_req_i,
  input  logic [127:0] m_addr_i,
  output logic [1:0]   grant_o,
  output logic         grant_vld_o,
  output logic [2:0]   slave_sel_o,
  output logic         unmapped_o,
  output logic         s_req_o,
  input  logic         s_ack_i,
  output logic [3:0]   m_ack_o,
  output logic         hold_flag_o,
  output logic         timeout_o
);

  localparam logic [4:0] NS = 5'(NUM_SLAVES);

  rib_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [2:0] slave_q, slave_d;
  logic       rr_q, rr_d;

  logic [3:0][31:0] addr_w;
  logic             hi_win;
  logic             hi_vld;
  logic             arb_vld;
  logic [1:0]       arb_id;
  logic [31:0]      win_addr;
  logic             win_unm;
  logic             win_slow;

  assign addr_w = m_addr_i;

  rib_rr_pick2 u_rr (
    .req_i (m_req_i[3:2]),
    .ptr_i (rr_q),
    .win_o (hi_win),
    .vld_o (hi_vld)
  );

  // JTAG/UART outrank core data, which outranks fetch
  always_comb begin
    arb_vld = 1'b1;
    arb_id  = RIB_M_CORE;
    unique case (1'b1)
      hi_vld:
        arb_id = hi_win ? RIB_M_UART : RIB_M_JTAG;
      !hi_vld && m_req_i[0]:
        arb_id = RIB_M_CORE;
      !hi_vld && !m_req_i[0] && m_req_i[1]:
        arb_id = RIB_M_FETCH;
      default: begin
        arb_vld = 1'b0;
        arb_id  = RIB_M_CORE;
      end
    endcase
  end

  assign win_addr = addr_w[arb_id];
  assign win_unm  = {1'b0, win_addr[31:28]} >= NS;
  assign win_slow = !win_unm && SLOW_SLAVE_MASK[win_addr[30:28]];

`ifdef RIB_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    slave_d     = slave_q;
    rr_d        = rr_q;
    grant_o     = 2'd0;
    grant_vld_o = 1'b0;
    slave_sel_o = 3'd0;
    unmapped_o  = 1'b0;
    s_req_o     = 1'b0;
    m_ack_o     = 4'd0;
    hold_flag_o = 1'b0;
    timeout_o   = 1'b0;
`ifdef RIB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ARB: begin
        if (arb_vld) begin
          grant_o     = arb_id;
          grant_vld_o = 1'b1;
          slave_sel_o = win_addr[30:28];
          unmapped_o  = win_unm;
          hold_flag_o = arb_id[1];
          if (win_slow) begin
            owner_d = arb_id;
            slave_d = win_addr[30:28];
            state_d = BUSY;
`ifdef RIB_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            m_ack_o[arb_id] = 1'b1;
            // point at the other of m2/m3
            if (arb_id[1]) rr_d = ~arb_id[0];
          end
        end
      end
      BUSY: begin
        grant_o     = owner_q;
        grant_vld_o = 1'b1;
        slave_sel_o = slave_q;
        s_req_o     = 1'b1;
        hold_flag_o = 1'b1;
        if (s_ack_i) begin
          m_ack_o[owner_q] = 1'b1;
          state_d          = ARB;
          if (owner_q[1]) rr_d = ~owner_q[0];
`ifdef RIB_ARB_TIMEOUT_EN
        end else if (cnt_q == TMO_LAST) begin
          timeout_o        = 1'b1;
          m_ack_o[owner_q] = 1'b1;
          state_d          = ARB;
          if (owner_q[1]) rr_d = ~owner_q[0];
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      owner_q <= RIB_M_CORE;
      slave_q <= RIB_S0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      slave_q <= slave_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Bench for rib_arbiter: directed steps plus random traffic
// checked against a cycle-level reference model of the arbiter rules.
module tb_rib_arbiter;
  import rib_pkg::*;

`ifdef RIB_ARB_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [7:0] MASK = 8'h80;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] addr;
  logic         sack;
  logic [1:0]   grant;
  logic         gvld;
  logic [2:0]   ssel;
  logic         unm;
  logic         sreq;
  logic [3:0]   mack;
  logic         hold;
  logic         tmo;

  rib_arbiter #(
    .NUM_SLAVES      (8),
    .SLOW_SLAVE_MASK (MASK),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (req),
    .m_addr_i    (addr),
    .grant_o     (grant),
    .grant_vld_o (gvld),
    .slave_sel_o (ssel),
    .unmapped_o  (unm),
    .s_req_o     (sreq),
    .s_ack_i     (sack),
    .m_ack_o     (mack),
    .hold_flag_o (hold),
    .timeout_o   (tmo)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model state
  bit mk = 1'b0;
  bit mb = 1'b0;
  int mo = 0;
  int ms = 0;
  bit mp = 1'b0;
  int mc = 0;

  // model expectations
  logic [1:0]  e_gr;
  logic        e_vld, e_unm, e_sreq, e_hold, e_tmo;
  logic [2:0]  e_sel;
  logic [3:0]  e_ack;
  int          e_win;
  bit          e_slow, e_done;
  logic [31:0] e_a;

  // last observed values
  logic [1:0] o_gr;
  logic       o_sreq, o_tmo;
  logic [3:0] o_ack;

  function automatic logic [127:0] A(logic [31:0] a0, logic [31:0] a1,
                                     logic [31:0] a2, logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic eval();
    e_gr = 0; e_vld = 0; e_sel = 0; e_unm = 0; e_sreq = 0;
    e_ack = 0; e_hold = 0; e_tmo = 0; e_win = -1;
    e_slow = 0; e_done = 0; e_a = 0;
    if (mb) begin
      e_gr = 2'(mo); e_vld = 1; e_sel = 3'(ms);
      e_sreq = 1; e_hold = 1;
      if (sack) begin
        e_ack[mo] = 1; e_done = 1;
      end else if (TMO_EN && mc == TMO) begin
        e_tmo = 1; e_ack[mo] = 1; e_done = 1;
      end
    end else begin
      if (req[2] && req[3]) e_win = mp ? 3 : 2;
      else if (req[2]) e_win = 2;
      else if (req[3]) e_win = 3;
      else if (req[0]) e_win = 0;
      else if (req[1]) e_win = 1;
      if (e_win >= 0) begin
        e_a    = addr[e_win*32 +: 32];
        e_gr   = 2'(e_win);
        e_vld  = 1;
        e_sel  = e_a[30:28];
        e_unm  = e_a[31];
        e_hold = (e_win >= 2);
        e_slow = !e_a[31] && MASK[e_a[30:28]];
        if (!e_slow) begin
          e_ack[e_win] = 1; e_done = 1;
        end
      end
    end
  endtask

  task automatic advance();
    if (rst) begin
      mk = 1; mb = 0; mp = 0; mc = 0;
    end else if (mk) begin
      if (mb) begin
        if (e_done) begin
          mb = 0;
          if (mo >= 2) mp = (mo == 2);
        end else begin
          mc++;
        end
      end else if (e_win >= 0) begin
        if (e_slow) begin
          mb = 1; mo = e_win; ms = int'(e_sel); mc = 1;
        end else if (e_win >= 2) begin
          mp = (e_win == 2);
        end
      end
    end
  endtask

  task automatic step(bit r, logic [3:0] q, logic [127:0] ad, bit k);
    rst = r; req = q; addr = ad; sack = k;
    @(negedge clk);
    eval();
    o_gr = grant; o_sreq = sreq; o_ack = mack; o_tmo = tmo;
    if (mk) begin
      chk("grant", 32'(grant), 32'(e_gr));
      chk("grant_vld", 32'(gvld), 32'(e_vld));
      chk("slave_sel", 32'(ssel), 32'(e_sel));
      chk("unmapped", 32'(unm), 32'(e_unm));
      chk("s_req", 32'(sreq), 32'(e_sreq));
      chk("m_ack", 32'(mack), 32'(e_ack));
      chk("hold", 32'(hold), 32'(e_hold));
      chk("timeout", 32'(tmo), 32'(e_tmo));
    end
    @(posedge clk);
    advance();
    #1;
  endtask

  int n_sreq, n_ack, n_tmo;
  logic [1:0] rr_exp [4];
  logic [127:0] ra;

  initial begin
    rst = 1; req = 0; addr = 0; sack = 0;
    rr_exp[0] = 2'd2; rr_exp[1] = 2'd3;
    rr_exp[2] = 2'd2; rr_exp[3] = 2'd3;

    // reset and idle
    step(1, 4'b0000, '0, 0);
    step(1, 4'b0000, '0, 0);
    step(0, 4'b0000, '0, 1);

    // fetch alone, then core over fetch
    step(0, 4'b0010, A(0, 32'h10, 0, 0), 0);
    chk("m1_ack", 32'(o_ack), 32'h2);
    step(0, 4'b0011, A(32'h1000_0000, 32'h10, 0, 0), 0);
    chk("m0_ack", 32'(o_ack), 32'h1);

    // JTAG/UART alternate
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b1110,
           A(0, 32'h10, 32'h2000_0000, 32'h3000_0000), 0);
      chk("rr_seq", 32'(o_gr), 32'(rr_exp[i]));
    end

    // slow access, ack 5 cycles after s_req rises, owner drops req
    step(0, 4'b0011, A(32'h7000_0004, 32'h10, 0, 0), 0);
    n_sreq = 0; n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, (i == 0) ? 4'b0011 : 4'b0010,
           A(32'h0000_0004, 32'h10, 0, 0), i == 5);
      n_sreq += int'(o_sreq);
      n_ack  += int'(o_ack[0]);
    end
    chk("busy_len", 32'(n_sreq), 32'd6);
    chk("ack_pulses", 32'(n_ack), 32'd1);
    step(0, 4'b0010, A(0, 32'h10, 0, 0), 1);
    chk("after_busy_sreq", 32'(o_sreq), 32'd0);

    // back-to-back: the gap cycle re-arbitrates to JTAG
    step(0, 4'b0011, A(32'h7000_0000, 32'h10, 0, 0), 0);
    step(0, 4'b0111, A(32'h7000_0000, 32'h10, 32'h10, 0), 0);
    step(0, 4'b0111, A(32'h7000_0000, 32'h10, 32'h10, 0), 1);
    step(0, 4'b0111, A(32'h7000_0000, 32'h10, 32'h10, 0), 0);
    chk("b2b_gap_grant", 32'(o_gr), 32'd2);

    // reset in the 3rd BUSY cycle, late ack ignored
    step(0, 4'b0001, A(32'h7000_0000, 0, 0, 0), 0);
    step(0, 4'b0001, A(32'h7000_0000, 0, 0, 0), 0);
    step(0, 4'b0001, A(32'h7000_0000, 0, 0, 0), 0);
    step(1, 4'b0001, A(32'h7000_0000, 0, 0, 0), 0);
    step(0, 4'b0000, '0, 1);
    chk("rst_busy_sreq", 32'(o_sreq), 32'd0);
    chk("rst_busy_ack", 32'(o_ack), 32'd0);

`ifdef RIB_ARB_TIMEOUT_EN
    // never acked: timeout in BUSY cycle 8
    step(0, 4'b0001, A(32'h7000_0000, 0, 0, 0), 0);
    n_tmo = 0;
    for (int i = 1; i <= TMO; i++) begin
      step(0, 4'b0000, '0, 0);
      n_tmo += int'(o_tmo);
    end
    chk("tmo_pulses", 32'(n_tmo), 32'd1);
    chk("tmo_ack", 32'(o_ack), 32'h1);
    // ack in cycle 8 beats timeout
    step(0, 4'b0001, A(32'h7000_0000, 0, 0, 0), 0);
    n_tmo = 0;
    for (int i = 1; i <= TMO; i++) begin
      step(0, 4'b0000, '0, i == TMO);
      n_tmo += int'(o_tmo);
    end
    chk("ack_beats_tmo", 32'(n_tmo), 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 4; k++)
        ra[k*32 +: 32] = {4'($urandom_range(0, 15)), 28'($urandom)};
      step($urandom_range(0, 99) == 0, 4'($urandom), ra,
           $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
